// File: rtl/pueo_trig_pkg.sv
`default_nettype none
//==============================================================================
// Module : pueo_trig_pkg
// Brief  : Shared types for the trigger event capture block: event record,
//          serializer state encoding and record field widths.
// Rev    : 1.0  initial release
//==============================================================================
package pueo_trig_pkg;

    localparam int NUM_TIO    = 4;
    localparam int META_WIDTH = 64;

    typedef struct packed {
        logic [31:0]                           evnum;
        logic [31:0]                           timestamp;
        logic [NUM_TIO-1:0][META_WIDTH-1:0]    meta;
    } event_rec_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        M0   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4,
        M3   = 3'd5
    } ser_state_e;

    function automatic logic [META_WIDTH-1:0] hdr_word(input event_rec_t rec);
        return {rec.evnum, rec.timestamp};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pueo_trig_event_capture_if.sv
`default_nettype none
//==============================================================================
// Module : pueo_trig_event_capture_if
// Brief  : Event record stream (valid/ready with last) between the capture
//          block and its consumer.
// Rev    : 1.0  initial release
//==============================================================================
interface pueo_trig_event_capture_if;

    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        output m_tready
    );

endinterface
`default_nettype wire

// File: rtl/pueo_event_fifo.sv
`default_nettype none
//==============================================================================
// Module : pueo_event_fifo
// Brief  : Synchronous FIFO of event records with first-word-fall-through read
//          port and full/empty/count status.
// Rev    : 1.0  initial release
//==============================================================================
module pueo_event_fifo
    import pueo_trig_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
)
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  event_rec_t    wr_data_i,
    input  logic          rd_en_i,
    output event_rec_t    rd_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    event_rec_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_wr;
    logic          do_rd;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_rd   = rd_en_i && !empty_o;
    // A write into a full FIFO is allowed when the head is leaving this cycle
    assign do_wr   = wr_en_i && (!full_o || do_rd);

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_wr) - CW'(do_rd);
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule
`default_nettype wire

// File: rtl/pueo_trig_event_capture.sv
`default_nettype none
//==============================================================================
// Module : pueo_trig_event_capture
// Brief  : Tags master triggers with event number and timestamp, buffers the
//          records and serializes each as HDR + four metadata beats.
// Option : PUEO_TRIG_TIMESTAMP_EN - include the 32-bit ce_i-qualified
//          timestamp counter; without it the header timestamp field is zero.
// Rev    : 1.0  initial release
//==============================================================================
module pueo_trig_event_capture
    import pueo_trig_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
)
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ce_i,
    input  logic                          trig_i,
    input  logic [META_WIDTH-1:0]         tio0_meta_i,
    input  logic [META_WIDTH-1:0]         tio1_meta_i,
    input  logic [META_WIDTH-1:0]         tio2_meta_i,
    input  logic [META_WIDTH-1:0]         tio3_meta_i,
    input  logic                          run_clr_i,
    output logic                          dead_o,
    pueo_trig_event_capture_if.master     m,
    output logic [15:0]                   drop_count_o,
    output logic [31:0]                   evnum_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // Reset asserts immediately but releases two clk_i edges later
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_int = rst_sync_q[1];

    logic [31:0] ts_cur;

`ifdef PUEO_TRIG_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] ts_d;

    assign ts_d   = run_clr_i ? 32'd0 : ts_q + {31'd0, ce_i};
    assign ts_cur = run_clr_i ? 32'd0 : ts_q;

    always_ff @(posedge clk_i or posedge rst_int) begin
        if (rst_int) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end
`else
    logic unused_ce;

    assign unused_ce = ce_i;
    assign ts_cur    = 32'd0;
`endif

    ser_state_e    state_q;
    ser_state_e    state_d;
    logic [31:0]   evnum_q;
    logic [31:0]   evnum_d;
    logic [31:0]   evnum_base;
    logic [15:0]   drop_q;
    logic [15:0]   drop_d;
    logic [15:0]   drop_base;
    logic          dead_q;
    logic          dead_d;
    logic [CW:0]   occ_next;

    event_rec_t    wr_rec;
    event_rec_t    head_rec;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          push;
    logic          pop;
    logic          beat_ok;

    logic [63:0]   tdata_w;
    logic          tvalid_w;
    logic          tlast_w;

    assign beat_ok = tvalid_w && m.m_tready;
    assign pop     = (state_q == M3) && m.m_tready;
    assign push    = trig_i && (!fifo_full || pop);

    always_comb begin
        wr_rec           = '0;
        wr_rec.evnum     = evnum_base;
        wr_rec.timestamp = ts_cur;
        wr_rec.meta[0]   = tio0_meta_i;
        wr_rec.meta[1]   = tio1_meta_i;
        wr_rec.meta[2]   = tio2_meta_i;
        wr_rec.meta[3]   = tio3_meta_i;
    end

    pueo_event_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_int),
        .wr_en_i    (push),
        .wr_data_i  (wr_rec),
        .rd_en_i    (pop),
        .rd_data_o  (head_rec),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // A run clear and a coincident trigger behave as if the clear came first
    always_comb begin
        evnum_base = run_clr_i ? 32'd0 : evnum_q;
        evnum_d    = evnum_base + {31'd0, trig_i};
        drop_base  = run_clr_i ? 16'd0 : drop_q;
        drop_d     = drop_base;
        if (trig_i && !push && (drop_base != 16'hFFFF)) begin
            drop_d = drop_base + 16'd1;
        end
        occ_next = {1'b0, fifo_count} + (CW+1)'(push) - (CW+1)'(pop);
        dead_d   = (occ_next >= (CW+1)'(FIFO_DEPTH - 1));
    end

    always_ff @(posedge clk_i or posedge rst_int) begin
        if (rst_int) begin
            evnum_q <= '0;
            drop_q  <= '0;
            dead_q  <= 1'b0;
        end else begin
            evnum_q <= evnum_d;
            drop_q  <= drop_d;
            dead_q  <= dead_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_int) begin
        if (rst_int) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tvalid_w = 1'b0;
        tlast_w  = 1'b0;
        tdata_w  = '0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = HDR;
            end
            HDR: begin
                tvalid_w = 1'b1;
                tdata_w  = hdr_word(head_rec);
                if (beat_ok) state_d = M0;
            end
            M0: begin
                tvalid_w = 1'b1;
                tdata_w  = head_rec.meta[0];
                if (beat_ok) state_d = M1;
            end
            M1: begin
                tvalid_w = 1'b1;
                tdata_w  = head_rec.meta[1];
                if (beat_ok) state_d = M2;
            end
            M2: begin
                tvalid_w = 1'b1;
                tdata_w  = head_rec.meta[2];
                if (beat_ok) state_d = M3;
            end
            M3: begin
                tvalid_w = 1'b1;
                tlast_w  = 1'b1;
                tdata_w  = head_rec.meta[3];
                // Chain straight into the next record when one remains queued
                if (beat_ok) begin
                    state_d = ((fifo_count > CW'(1)) || push) ? HDR : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m.m_tdata    = tdata_w;
    assign m.m_tvalid   = tvalid_w;
    assign m.m_tlast    = tlast_w;
    assign dead_o       = dead_q;
    assign drop_count_o = drop_q;
    assign evnum_o      = evnum_q;

endmodule
`default_nettype wire

// File: tb/tb_pueo_trig_event_capture.sv
`default_nettype none
//==============================================================================
// Module : tb_pueo_trig_event_capture
// Brief  : Directed self-checking bench for pueo_trig_event_capture.
// Rev    : 1.0  initial release
//==============================================================================
module tb_pueo_trig_event_capture;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ce_i;
    logic        trig_i;
    logic        run_clr_i;
    logic [63:0] tio0, tio1, tio2, tio3;
    logic        dead_o;
    logic [15:0] drop_count_o;
    logic [31:0] evnum_o;

    pueo_trig_event_capture_if m_axis ();

    pueo_trig_event_capture #(
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ce_i         (ce_i),
        .trig_i       (trig_i),
        .tio0_meta_i  (tio0),
        .tio1_meta_i  (tio1),
        .tio2_meta_i  (tio2),
        .tio3_meta_i  (tio3),
        .run_clr_i    (run_clr_i),
        .dead_o       (dead_o),
        .m            (m_axis),
        .drop_count_o (drop_count_o),
        .evnum_o      (evnum_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int hdr_cyc     = 0;
    int m3_cyc      = 0;
    int prev_m3     = 0;
    logic [63:0] got [5];

    always @(posedge clk_i) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [63:0] meta_of(input int t, input int k);
        return {8'hA5, t[23:0], k[23:0], 8'h5A};
    endfunction

    task automatic drive_meta(input int t);
        tio0 = meta_of(t, 0);
        tio1 = meta_of(t, 1);
        tio2 = meta_of(t, 2);
        tio3 = meta_of(t, 3);
    endtask

    // Collect one five-beat event; rnd stalls the consumer at random
    task automatic recv_event(input bit rnd, input string tag);
        int          beat    = 0;
        int          budget  = 300;
        bit          stalled = 1'b0;
        logic [63:0] hold_d  = '0;
        logic        hold_l  = 1'b0;
        while (beat < 5 && budget > 0) begin
            if (stalled) begin
                check({tag, " stall valid"}, 64'(m_axis.m_tvalid), 64'd1);
                check({tag, " stall data"},  m_axis.m_tdata, hold_d);
                check({tag, " stall last"},  64'(m_axis.m_tlast), 64'(hold_l));
            end
            m_axis.m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 1'b0;
            if (m_axis.m_tvalid) begin
                if (m_axis.m_tready) begin
                    got[beat] = m_axis.m_tdata;
                    check({tag, " tlast"}, 64'(m_axis.m_tlast), 64'(beat == 4));
                    if (beat == 0) hdr_cyc = cyc;
                    if (beat == 4) m3_cyc = cyc;
                    beat++;
                end else begin
                    stalled = 1'b1;
                    hold_d  = m_axis.m_tdata;
                    hold_l  = m_axis.m_tlast;
                end
            end
            tick();
            budget--;
        end
        if (beat != 5) check({tag, " timeout beats"}, 64'(beat), 64'd5);
    endtask

    task automatic expect_event(input string tag, input logic [31:0] evn,
                                input logic [31:0] ts, input int mtag);
        check({tag, " evnum"}, 64'(got[0][63:32]), 64'(evn));
        check({tag, " ts"},    64'(got[0][31:0]),  64'(ts));
        for (int k = 0; k < 4; k++) begin
            check({tag, " meta"}, got[k+1], meta_of(mtag, k));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ts_b_exp;
        rst_i = 1'b1; ce_i = 1'b0; trig_i = 1'b0; run_clr_i = 1'b0;
        tio0 = '0; tio1 = '0; tio2 = '0; tio3 = '0;
        m_axis.m_tready = 1'b0;
        repeat (3) tick();
        check("rst tvalid", 64'(m_axis.m_tvalid), 64'd0);
        check("rst tlast",  64'(m_axis.m_tlast),  64'd0);
        check("rst tdata",  m_axis.m_tdata,       64'd0);
        check("rst dead",   64'(dead_o),          64'd0);
        check("rst drop",   64'(drop_count_o),    64'd0);
        check("rst evnum",  64'(evnum_o),         64'd0);
        rst_i = 1'b0;
        repeat (4) tick();

        // Single event, latency and beat order
        m_axis.m_tready = 1'b1;
        tio0 = 64'h1111_1111_1111_1111; tio1 = 64'h2222_2222_2222_2222;
        tio2 = 64'h3333_3333_3333_3333; tio3 = 64'h4444_4444_4444_4444;
        trig_i = 1'b1; tick(); trig_i = 1'b0;
        check("t1 N+1 tvalid", 64'(m_axis.m_tvalid), 64'd0);
        check("t1 evnum_o",    64'(evnum_o),         64'd1);
        tick();
        check("t1 HDR at N+2", 64'(m_axis.m_tvalid), 64'd1);
        check("t1 HDR word",   m_axis.m_tdata,       64'd0);
        recv_event(1'b0, "t1");
        check("t1 beat HDR", got[0], 64'd0);
        check("t1 beat M0",  got[1], 64'h1111_1111_1111_1111);
        check("t1 beat M1",  got[2], 64'h2222_2222_2222_2222);
        check("t1 beat M2",  got[3], 64'h3333_3333_3333_3333);
        check("t1 beat M3",  got[4], 64'h4444_4444_4444_4444);
        check("t1 tlast at N+6", 64'(m3_cyc - hdr_cyc), 64'd4);
        check("t1 idle after", 64'(m_axis.m_tvalid), 64'd0);

        // Overflow: DEPTH+2 triggers with consumer stalled
        run_clr_i = 1'b1; tick(); run_clr_i = 1'b0;
        check("t2 clr evnum", 64'(evnum_o), 64'd0);
        m_axis.m_tready = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            drive_meta(10 + k);
            trig_i = 1'b1;
            tick();
            check("t2 dead", 64'(dead_o), 64'((k + 1) >= (DEPTH - 1)));
        end
        trig_i = 1'b0;
        check("t2 drop_count", 64'(drop_count_o), 64'd2);
        check("t2 evnum_o",    64'(evnum_o),      64'(DEPTH + 2));
        for (int k = 0; k < DEPTH; k++) begin
            recv_event(1'b0, "t2");
            expect_event("t2", 32'(k), 32'd0, 10 + k);
            if (k > 0) check("t2 back-to-back gap", 64'(hdr_cyc - prev_m3), 64'd1);
            prev_m3 = m3_cyc;
        end
        check("t2 dead drained",   64'(dead_o),          64'd0);
        check("t2 tvalid drained", 64'(m_axis.m_tvalid), 64'd0);

        // Random backpressure over three queued events
        run_clr_i = 1'b1; tick(); run_clr_i = 1'b0;
        check("t3 clr drop", 64'(drop_count_o), 64'd0);
        m_axis.m_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_meta(20 + k);
            trig_i = 1'b1;
            tick();
        end
        trig_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            recv_event(1'b1, "t3");
            expect_event("t3", 32'(k), 32'd0, 20 + k);
        end

        // Push into a full FIFO on the same cycle as the M3 pop
        m_axis.m_tready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            drive_meta(30 + k);
            trig_i = 1'b1;
            tick();
        end
        trig_i = 1'b0;
        check("t4 full dead", 64'(dead_o), 64'd1);
        m_axis.m_tready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (m_axis.m_tvalid && m_axis.m_tlast) break;
            tick();
        end
        check("t4 reached M3", 64'(m_axis.m_tlast), 64'd1);
        drive_meta(34);
        trig_i = 1'b1; tick(); trig_i = 1'b0;
        check("t4 drop unchanged", 64'(drop_count_o), 64'd0);
        check("t4 evnum_o",        64'(evnum_o),      64'd8);
        check("t4 still full",     64'(dead_o),       64'd1);
        for (int k = 0; k < DEPTH; k++) begin
            recv_event(1'b0, "t4");
            expect_event("t4", 32'(4 + k), 32'd0, 31 + k);
        end

        // Reset during beat M1
        m_axis.m_tready = 1'b1;
        drive_meta(40);
        trig_i = 1'b1; tick(); trig_i = 1'b0;
        tick();
        check("t5 HDR valid", 64'(m_axis.m_tvalid), 64'd1);
        tick(); tick();
        check("t5 in M1", m_axis.m_tdata, meta_of(40, 1));
        #2 rst_i = 1'b1;
        #1;
        check("t5 async tvalid", 64'(m_axis.m_tvalid), 64'd0);
        check("t5 async tlast",  64'(m_axis.m_tlast),  64'd0);
        check("t5 async tdata",  m_axis.m_tdata,       64'd0);
        check("t5 async evnum",  64'(evnum_o),         64'd0);
        tick(); tick();
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5 fifo empty", 64'(m_axis.m_tvalid), 64'd0);
        end
        drive_meta(41);
        trig_i = 1'b1; tick(); trig_i = 1'b0;
        recv_event(1'b0, "t5");
        expect_event("t5", 32'd0, 32'd0, 41);

        // Timestamp across ten clocks with ce_i on alternate cycles
        m_axis.m_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ce_i      = i[0];
            run_clr_i = (i == 0);
            trig_i    = (i == 0);
            if (i == 0) drive_meta(50);
            tick();
            if (i == 0) check("t6 clr+trig evnum_o", 64'(evnum_o), 64'd1);
            trig_i    = 1'b0;
            run_clr_i = 1'b0;
        end
        ce_i = 1'b0;
        drive_meta(51);
        trig_i = 1'b1; tick(); trig_i = 1'b0;
`ifdef PUEO_TRIG_TIMESTAMP_EN
        ts_b_exp = 32'd5;
`else
        ts_b_exp = 32'd0;
`endif
        recv_event(1'b0, "t6a");
        expect_event("t6a", 32'd0, 32'd0, 50);
        recv_event(1'b0, "t6b");
        expect_event("t6b", 32'd1, ts_b_exp, 51);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pueo_trig_event_capture.md
PUEO_TRIG_EVENT_CAPTURE -- requirements
Module: pueo_trig_event_capture

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter FIFO_DEPTH SHALL default to 4: number of event records buffered, power of two, range 2..16.
REQ-003 The port clk_i SHALL be an input, 1 bit wide: system clock.
REQ-004 The port rst_i SHALL be an input, 1 bit wide: asynchronous active-high reset.
REQ-005 The port ce_i SHALL be an input, 1 bit wide: sysclk_x2 phase enable, which qualifies the timestamp count.
REQ-006 The port trig_i SHALL be an input, 1 bit wide: single-cycle master trigger pulse from the level-two stage.
REQ-007 The ports tio0_meta_i..tio3_meta_i SHALL be inputs, 64 bits each: delay-matched per-TURFIO metadata, valid in the trig_i cycle.
REQ-008 The port run_clr_i SHALL be an input, 1 bit wide: synchronous clear of the event number, drop counter and timestamp.
REQ-009 The port dead_o SHALL be an output, 1 bit wide: buffer almost-full, fed back to the level-two dead input.
REQ-010 The ports m_tdata, m_tvalid, m_tready and m_tlast SHALL be respectively output 64 bits, output 1 bit, input 1 bit and output 1 bit: the event record stream.
REQ-011 The port drop_count_o SHALL be an output, 16 bits wide: saturating count of triggers discarded while the buffer was full.
REQ-012 The port evnum_o SHALL be an output, 32 bits wide: the next event number to be assigned.

Function
REQ-013 On trig_i=1, the block SHALL assign the current event number (evnum) to the trigger and increment evnum by 1, wrapping 0xFFFFFFFF->0; this applies whether or not the record is stored.
REQ-014 On trig_i=1 with the buffer not full, the block SHALL write {evnum, timestamp, tio0..3_meta_i} into the FIFO; the occupancy update SHALL be visible the next cycle.
REQ-015 On trig_i=1 with the buffer full, the block SHALL discard the record and increment drop_count_o, saturating at 0xFFFF.
REQ-016 dead_o SHALL be registered and equal 1 iff occupancy >= FIFO_DEPTH-1; the spare slot absorbs the one-cycle trigger already in flight.
REQ-017 The output serializer SHALL be an FSM with states IDLE, HDR, M0, M1, M2, M3.
REQ-018 IDLE->HDR SHALL occur when the FIFO is non-empty.
REQ-019 Each subsequent state SHALL advance only on m_tvalid && m_tready; M3->IDLE, or M3->HDR if the FIFO is non-empty.
REQ-020 The HDR word SHALL be {evnum[31:0], timestamp[31:0]}, and words Mk SHALL be tio<k>_meta.
REQ-021 m_tlast SHALL be 1 only in state M3.
REQ-022 The FIFO record SHALL be popped on the accepted M3 beat.
REQ-023 m_tvalid SHALL be 1 in states HDR..M3; m_tdata and m_tlast SHALL be stable while m_tvalid && !m_tready.
REQ-024 Back-to-back accepted events SHALL produce no idle cycle between them.
REQ-025 Latency: trig_i at cycle N with the FIFO empty and m_tready=1 SHALL produce the HDR beat at N+2 and m_tlast at N+6.
REQ-026 A simultaneous trig_i push and M3 pop SHALL both take effect, leaving occupancy unchanged; a push into a full FIFO coinciding with a pop SHALL be accepted.
REQ-027 run_clr_i SHALL clear evnum, drop_count_o and timestamp and SHALL NOT flush the FIFO; trig_i coincident with run_clr_i SHALL be assigned event 0 and leave evnum=1.
REQ-028 evnum_o SHALL reflect evnum after that cycle's update.

Reset
REQ-029 rst_i SHALL asynchronously set the FIFO empty and the FSM to IDLE.
REQ-030 rst_i SHALL set m_tvalid=0, m_tlast=0, m_tdata=0, dead_o=0, drop_count_o=0, evnum_o=0 and timestamp=0.
REQ-031 rst_i asserted mid-event SHALL abandon the event without emitting m_tlast, and SHALL discard buffered records.
REQ-032 Release of rst_i SHALL be synchronized internally to clk_i.

Configuration
REQ-033 With macro PUEO_TRIG_TIMESTAMP_EN defined, timestamp SHALL be a free-running 32-bit counter incrementing on clk_i cycles with ce_i=1, wrapping.
REQ-034 Without PUEO_TRIG_TIMESTAMP_EN, the counter SHALL be absent and HDR[31:0] SHALL be 0.

Structure
REQ-035 Package pueo_trig_pkg SHALL hold the event record struct, the serializer state enum, NUM_TIO=4 and META_WIDTH=64.
REQ-036 Sub-module pueo_event_fifo SHALL be a synchronous FIFO of records with full, empty and count outputs; the block SHALL contain no other sub-module.

Verification
REQ-037 The bench SHALL drive a single trig_i with meta words 0x11..,0x22..,0x33..,0x44.. and m_tready=1, and SHALL check five beats: HDR evnum=0, meta in order, m_tlast on beat 5, HDR at N+2.
REQ-038 The bench SHALL drive FIFO_DEPTH+2 triggers with m_tready=0, and SHALL check that dead_o rises after DEPTH-1 pushes, drop_count_o=2 and evnum_o=DEPTH+2.
REQ-039 The bench SHALL toggle m_tready randomly over 3 queued events, and SHALL check that data holds under stall, events arrive in order, and evnum is 0,1,2.
REQ-040 The bench SHALL assert trig_i on the same cycle as an M3 pop with the FIFO full, and SHALL check that the record is accepted and drop_count_o is unchanged.
REQ-041 The bench SHALL assert rst_i during beat M1, and SHALL check that m_tvalid=0 asynchronously, the FIFO is empty and the next trigger emits evnum 0.
REQ-042 With PUEO_TRIG_TIMESTAMP_EN, the bench SHALL apply ce_i on alternate cycles and check that timestamp advances by 5 over 10 clocks; without the macro it SHALL check HDR[31:0]=0.
